systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
Upstream feeder for an NxN systolic array of FP32 multiply-accumulate PEs. Each PE registers its in_a/in_b through to out_a/out_b and accumulates in_a*in_b into out_c. This block buffers an NxN A matrix and an NxN B matrix written by the host. On start, it clears the PE accumulators, then streams A rows into the array's west edge and B columns into its north edge, with diagonal skew and zero padding. It signals when the array's out_c values hold C = A*B.

Parameters:
N, 4, array dimension; matrices are NxN; lanes per edge = N
DW, 32, element width (IEEE-754 single; block treats data as opaque bits)
AW, 4, write address width; must satisfy 2^AW >= N*N

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe for matrix storage
wr_sel  in  1  0 = write A, 1 = write B
wr_addr  in  AW  element index = row*N + col; indices >= N*N ignored
wr_data  in  DW  element value
start  in  1  begin a multiply; sampled only in IDLE
busy  out  1  high in CLEAR, FEED and DONE
pe_clr  out  1  one-cycle accumulator clear; integrator ORs it into the PE reset
a_out  out  N*DW  west-edge lanes; lane i at bits [i*DW +: DW] drives PE row i in_a
b_out  out  N*DW  north-edge lanes; lane j at bits [j*DW +: DW] drives PE column j in_b
done  out  1  one-cycle pulse; array out_c valid
results_valid  out  1  high from DONE until next accepted start, accepted write, or reset

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy, pe_clr, done, results_valid = 0; a_out, b_out = 0; all A/B storage cleared to 0; feed counter t = 0.
- Reset asserted mid-operation (any state) aborts at the next edge with the same values. No done pulse is issued.
- Storage: two NxN DW-bit register arrays. A write lands at the clock edge when wr_en=1, state=IDLE and wr_addr < N*N.
- Writes while busy=1 are dropped, with no side effects.
- An accepted write clears results_valid.
- FSM:
  - IDLE: start=1 moves to CLEAR and clears results_valid. A write and a start in the same cycle both take effect.
  - CLEAR: exactly 1 cycle with pe_clr=1; a_out and b_out are 0. Moves to FEED with t=0.
  - FEED: exactly 3N-2 cycles, t = 0 .. 3N-3; t increments every cycle. At t=3N-3 moves to DONE.
  - DONE: 1 cycle with done=1, results_valid set to 1, a_out and b_out = 0. Moves to IDLE.
- start is ignored outside IDLE, with no queuing.
- Lane data during the FEED cycle with count t (registered outputs, stable for the whole cycle):
  - a_out lane i = A[i][t-i] when 0 <= t-i < N, else 0.
  - b_out lane j = B[t-j][j] when 0 <= t-j < N, else 0.
  - Zero padding is bit pattern 32'h0, which the PEs treat as FP zero and which adds nothing to the accumulators.
- Timing from start sampled in cycle 0:
  - CLEAR is cycle 1.
  - FEED covers cycles 2 .. 3N-1.
  - DONE is cycle 3N, with done=1.
  - busy is high in cycles 1 .. 3N.
- Correctness basis: PE(i,j) accumulates A[i][k]*B[k][j] during FEED count i+j+k. The last product, i=j=k=N-1, registers at the end of t=3N-3, so out_c is valid when DONE begins.
- Outputs never show X. No storage is read outside FEED.

Test Plan:
- Skew check (N=4): write A[r][c] = 32'h1000+r*4+c and B[r][c] = 32'h2000+r*4+c, then pulse start. Required:
  - pe_clr=1 only in cycle 1.
  - At t=2: a_out lane0 = 32'h1002, lane1 = 32'h1005, lane2 = 32'h1008, lane3 = 0.
  - At t=2: b_out lane0 = 32'h2008, lane1 = 32'h2005, lane2 = 32'h2002, lane3 = 0.
  - At t=9: all lanes = 0.
- End-to-end with 4x4 PE array: A = identity (3F800000 on the diagonal, 0 elsewhere), B[r][c] = float(r*4+c+1). Required: done in cycle 12, and every out_c equals the matching B element exactly.
- start pulsed in cycles 3 and 7 while busy: no effect; done still occurs only in cycle 12 and busy drops in cycle 13.
- wr_en to A[0][0] with 32'h40000000 during FEED: storage unchanged; a second run reproduces the first run's lane values.
- Reset asserted at t=4: next cycle state=IDLE, all outputs 0, no done. A fresh start then yields zero lanes throughout FEED, because storage was cleared.
- Write with wr_addr=16 (N=4): ignored. A write in IDLE after done drops results_valid to 0 on the same edge.

Source files
------------

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feeder
// Purpose  : Buffers an NxN A matrix and an NxN B matrix written by the host,
//            then feeds an NxN multiply-accumulate systolic array. A run
//            clears the PE accumulators for one cycle, then streams skewed,
//            zero-padded A rows into the west edge and B columns into the
//            north edge for 3N-2 cycles, then pulses done once the array's
//            out_c values hold C = A*B.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            wr_en/wr_sel/wr_addr/wr_data
//                                - host element write (sel 0 = A, 1 = B;
//                                  addr = row*N + col, ignored when busy
//                                  or out of range)
//            start               - begin a run (accepted only when idle)
//            busy                - run in progress (CLEAR, FEED, DONE)
//            pe_clr              - one-cycle accumulator clear
//            a_out / b_out       - west / north edge lanes, lane i at
//                                  bits [i*DW +: DW]
//            done                - one-cycle pulse, array results valid
//            results_valid       - results held since the last DONE
// Revision : 1.0 - initial release
// ============================================================================
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    output logic            busy,
    output logic            pe_clr,
    output logic [N*DW-1:0] a_out,
    output logic [N*DW-1:0] b_out,
    output logic            done,
    output logic            results_valid
);

    localparam int C_TLAST = 3 * N - 3;
    localparam int C_TW    = (3 * N - 2 > 1) ? $clog2(3 * N - 2) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_FEED  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [C_TW-1:0]   t_q, t_d;
    logic [DW-1:0]     a_mem_q [N][N];
    logic [DW-1:0]     a_mem_d [N][N];
    logic [DW-1:0]     b_mem_q [N][N];
    logic [DW-1:0]     b_mem_d [N][N];
    logic [N*DW-1:0]   a_out_q, a_out_d;
    logic [N*DW-1:0]   b_out_q, b_out_d;
    logic              busy_q, busy_d;
    logic              pe_clr_q, pe_clr_d;
    logic              done_q, done_d;
    logic              results_valid_q, results_valid_d;

    logic              wr_ok;
    logic              lanes_on;
    logic [C_TW-1:0]   t_feed;

    always_comb begin
        state_d         = state_q;
        t_d             = t_q;
        a_mem_d         = a_mem_q;
        b_mem_d         = b_mem_q;
        a_out_d         = '0;
        b_out_d         = '0;
        busy_d          = busy_q;
        pe_clr_d        = 1'b0;
        done_d          = 1'b0;
        results_valid_d = results_valid_q;
        lanes_on        = 1'b0;
        t_feed          = '0;

        // Storage only changes while idle; out-of-range addresses fall away.
        wr_ok = wr_en && (state_q == S_IDLE) && (int'(wr_addr) < N * N);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (wr_ok && (int'(wr_addr) == r * N + c)) begin
                    if (wr_sel) b_mem_d[r][c] = wr_data;
                    else        a_mem_d[r][c] = wr_data;
                end
            end
        end
        if (wr_ok) results_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d         = S_CLEAR;
                    busy_d          = 1'b1;
                    pe_clr_d        = 1'b1;
                    results_valid_d = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d  = S_FEED;
                busy_d   = 1'b1;
                t_d      = '0;
                lanes_on = 1'b1;
                t_feed   = '0;
            end
            S_FEED: begin
                busy_d = 1'b1;
                if (t_q == C_TW'(C_TLAST)) begin
                    state_d         = S_DONE;
                    t_d             = '0;
                    done_d          = 1'b1;
                    results_valid_d = 1'b1;
                end else begin
                    t_d      = t_q + C_TW'(1);
                    lanes_on = 1'b1;
                    t_feed   = t_q + C_TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Lanes are registered, so they are computed for the count of the
        // upcoming FEED cycle. Lane i carries A[i][t-i]; lane j carries
        // B[t-j][j]; anything outside the matrix is zero padding.
        if (lanes_on) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(t_feed) == i + k) begin
                        a_out_d[i*DW +: DW] = a_mem_q[i][k];
                        b_out_d[i*DW +: DW] = b_mem_q[k][i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            t_q             <= '0;
            a_out_q         <= '0;
            b_out_q         <= '0;
            busy_q          <= 1'b0;
            pe_clr_q        <= 1'b0;
            done_q          <= 1'b0;
            results_valid_q <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem_q[r][c] <= '0;
                    b_mem_q[r][c] <= '0;
                end
            end
        end else begin
            state_q         <= state_d;
            t_q             <= t_d;
            a_out_q         <= a_out_d;
            b_out_q         <= b_out_d;
            busy_q          <= busy_d;
            pe_clr_q        <= pe_clr_d;
            done_q          <= done_d;
            results_valid_q <= results_valid_d;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem_q[r][c] <= a_mem_d[r][c];
                    b_mem_q[r][c] <= b_mem_d[r][c];
                end
            end
        end
    end

    assign busy          = busy_q;
    assign pe_clr        = pe_clr_q;
    assign a_out         = a_out_q;
    assign b_out         = b_out_q;
    assign done          = done_q;
    assign results_valid = results_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_feeder
// Purpose  : Self-checking bench for systolic_feeder. A matrix-level model
//            predicts every busy cycle's edge lanes and the product C = A*B;
//            a monitor compares the DUT lanes and a behavioural integer MAC
//            array driven by those lanes against the predictions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 5;   // one spare bit so out-of-range addresses exist

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_en;
    logic            wr_sel;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic            busy;
    logic            pe_clr;
    logic [N*DW-1:0] a_out;
    logic [N*DW-1:0] b_out;
    logic            done;
    logic            results_valid;

    systolic_feeder #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_sel        (wr_sel),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start         (start),
        .busy          (busy),
        .pe_clr        (pe_clr),
        .a_out         (a_out),
        .b_out         (b_out),
        .done          (done),
        .results_valid (results_valid)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural MAC array (integer products) ----------
    logic [DW-1:0] pa  [N][N];
    logic [DW-1:0] pb  [N][N];
    logic [DW-1:0] pc  [N][N];
    logic [DW-1:0] ina [N][N];
    logic [DW-1:0] inb [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ina[i][j] = (j == 0) ? a_out[i*DW +: DW] : pa[i][(j == 0) ? 0 : j - 1];
                inb[i][j] = (i == 0) ? b_out[j*DW +: DW] : pb[(i == 0) ? 0 : i - 1][j];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (reset || pe_clr) begin
                    pa[i][j] <= '0;
                    pb[i][j] <= '0;
                    pc[i][j] <= '0;
                end else begin
                    pa[i][j] <= ina[i][j];
                    pb[i][j] <= inb[i][j];
                    pc[i][j] <= pc[i][j] + ina[i][j] * inb[i][j];
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic            pe_clr;
        logic            done;
        logic [N*DW-1:0] a;
        logic [N*DW-1:0] b;
    } exp_t;

    exp_t                trace_q [$];
    logic [N*N*DW-1:0]   cexp_q  [$];
    int                  n_checks = 0;
    int                  n_fail   = 0;
    bit                  mon_en   = 1'b0;

    // Reference model: matrix contents and run status
    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];
    bit            model_busy;
    bit            model_rv;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
        end
    endtask

    // Predict the whole busy window of one run plus the product matrix.
    task automatic push_expect();
        exp_t              e;
        logic [N*N*DW-1:0] cm;
        logic [DW-1:0]     acc;
        e = '0;
        e.pe_clr = 1'b1;
        trace_q.push_back(e);
        for (int t = 0; t <= 3 * N - 3; t++) begin
            e = '0;
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < N) begin
                    e.a[i*DW +: DW] = ma[i][t-i];
                    e.b[i*DW +: DW] = mb[t-i][i];
                end
            end
            trace_q.push_back(e);
        end
        e = '0;
        e.done = 1'b1;
        trace_q.push_back(e);
        cm = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = '0;
                for (int k = 0; k < N; k++) acc = acc + ma[i][k] * mb[k][j];
                cm[(i*N+j)*DW +: DW] = acc;
            end
        end
        cexp_q.push_back(cm);
    endtask

    exp_t              mon_e;
    logic [N*N*DW-1:0] mon_c;

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy === 1'b1) begin
                if (trace_q.size() == 0) begin
                    check("busy_unexpected", 512'(busy), 512'(0));
                end else begin
                    mon_e = trace_q.pop_front();
                    check("pe_clr", 512'(pe_clr), 512'(mon_e.pe_clr));
                    check("done",   512'(done),   512'(mon_e.done));
                    check("a_out",  512'(a_out),  512'(mon_e.a));
                    check("b_out",  512'(b_out),  512'(mon_e.b));
                    if (mon_e.done && cexp_q.size() != 0) begin
                        mon_c = cexp_q.pop_front();
                        for (int i = 0; i < N; i++) begin
                            for (int j = 0; j < N; j++) begin
                                check($sformatf("out_c[%0d][%0d]", i, j),
                                      512'(pc[i][j]), 512'(mon_c[(i*N+j)*DW +: DW]));
                            end
                        end
                    end
                end
            end else begin
                check("idle_outputs", 512'({pe_clr, done, a_out, b_out}), 512'(0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_write(input logic sel, input int addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = data;
        if (!model_busy && addr < N * N) begin
            if (sel) mb[addr / N][addr % N] = data;
            else     ma[addr / N][addr % N] = data;
            model_rv = 1'b0;
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_random();
        for (int a = 0; a < N * N; a++) begin
            do_write(1'b0, a, DW'($urandom));
            do_write(1'b1, a, DW'($urandom));
        end
        do_write(1'($urandom_range(0, 1)), $urandom_range(N * N, (1 << AW) - 1), DW'($urandom));
    endtask

    // meddle: start pulses in cycles 3 and 7 and an A[0][0] write in cycle 5.
    // abort_at: cycle in which reset is raised (0 = no abort).
    task automatic run(input bit meddle, input int abort_at);
        bit aborted = 1'b0;
        push_expect();
        start = 1'b1;
        tick();
        start      = 1'b0;
        model_busy = 1'b1;
        model_rv   = 1'b0;
        check("rv_cleared_by_start", 512'(results_valid), 512'(model_rv));
        for (int c = 1; c <= 3 * N; c++) begin
            if (meddle) begin
                start = (c == 3 || c == 7);
                if (c == 5) begin
                    wr_en   = 1'b1;
                    wr_sel  = 1'b0;
                    wr_addr = '0;
                    wr_data = 32'h4000_0000;
                end else begin
                    wr_en = 1'b0;
                end
            end
            if (abort_at == c) begin
                reset   = 1'b1;
                aborted = 1'b1;
                break;
            end
            tick();
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (aborted) begin
            tick();
            reset = 1'b0;
            trace_q.delete();
            cexp_q.delete();
            clear_model();
            model_busy = 1'b0;
            model_rv   = 1'b0;
            check("abort_outputs", 512'({busy, pe_clr, done, results_valid, a_out, b_out}), 512'(0));
        end else begin
            model_busy = 1'b0;
            model_rv   = 1'b1;
            check("busy_dropped", 512'(busy), 512'(0));
            check("rv_after_done", 512'(results_valid), 512'(model_rv));
            check("trace_consumed", 512'(trace_q.size()), 512'(0));
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        clear_model();
        model_busy = 1'b0;
        model_rv   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_state", 512'({busy, pe_clr, done, results_valid, a_out, b_out}), 512'(0));
        mon_en = 1'b1;

        // Skew pattern, then busy-time starts/write, then a repeat run
        for (int a = 0; a < N * N; a++) begin
            do_write(1'b0, a, 32'h1000 + DW'(a));
            do_write(1'b1, a, 32'h2000 + DW'(a));
        end
        run(1'b0, 0);
        run(1'b1, 0);
        run(1'b0, 0);

        // Out-of-range write leaves results_valid; a real write drops it
        do_write(1'b0, N * N, 32'hDEAD_BEEF);
        check("rv_oob_write", 512'(results_valid), 512'(model_rv));
        do_write(1'b1, 3, 32'h0000_0055);
        check("rv_write_clear", 512'(results_valid), 512'(model_rv));
        run(1'b0, 0);

        // Identity times a ramp
        for (int a = 0; a < N * N; a++) begin
            do_write(1'b0, a, (a / N == a % N) ? 32'd1 : 32'd0);
            do_write(1'b1, a, DW'(a + 1));
        end
        run(1'b0, 0);

        repeat (4) begin
            load_random();
            run(1'b0, 0);
        end

        // Abort at feed count 4 (cycle 6), then a run over cleared storage
        load_random();
        run(1'b0, 6);
        repeat (3) tick();
        run(1'b0, 0);

        repeat (2) tick();
        check("final_trace_empty", 512'(trace_q.size()), 512'(0));
        check("final_c_empty", 512'(cexp_q.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
